// File: rtl/sprite_collision_unit.sv
// Per-frame sprite collision detector: accumulates pairwise sprite overlaps over a frame
// and publishes a latched pair vector, first-hit position, hit count and irq at each frame strobe.
module sprite_collision_unit #(
  parameter int N_SPRITES    = 4,
  parameter int SCREEN_CORDW = 16,
  parameter int CNTW         = 12,
  parameter int STICKY       = 0,
  localparam int NPAIRS      = N_SPRITES * (N_SPRITES - 1) / 2
) (
  input  logic                    clk_pix,
  input  logic                    rst,
  input  logic                    frame,
  input  logic                    de,
  input  logic [SCREEN_CORDW-1:0] screen_x,
  input  logic [SCREEN_CORDW-1:0] screen_y,
  input  logic [N_SPRITES-1:0]    drawing,
  input  logic [NPAIRS-1:0]       pair_mask,
  input  logic                    clear,
  output logic [NPAIRS-1:0]       collisions,
  output logic                    any_collision,
  output logic [SCREEN_CORDW-1:0] first_x,
  output logic [SCREEN_CORDW-1:0] first_y,
  output logic                    first_valid,
  output logic [CNTW-1:0]         hit_count,
  output logic                    irq
);

  logic [NPAIRS-1:0]       hit;
  logic                    hit_any;

  logic [NPAIRS-1:0]       acc_pairs;
  logic [CNTW-1:0]         acc_count;
  logic                    acc_valid;
  logic [SCREEN_CORDW-1:0] acc_x;
  logic [SCREEN_CORDW-1:0] acc_y;

  logic [CNTW-1:0]         acc_count_inc;
  logic [CNTW:0]           sticky_sum;
  logic [CNTW-1:0]         sticky_count;

  // Pair k = (i,j), i<j, enumerated i-major.
  for (genvar i = 0; i < N_SPRITES; i++) begin : g_row
    for (genvar j = i + 1; j < N_SPRITES; j++) begin : g_col
      localparam int K = i * N_SPRITES - i * (i + 1) / 2 + j - i - 1;
      assign hit[K] = de & drawing[i] & drawing[j] & pair_mask[K];
    end
  end

  assign hit_any       = |hit;
  assign any_collision = |collisions;

  assign acc_count_inc = (acc_count == {CNTW{1'b1}}) ? acc_count : acc_count + 1'b1;
  assign sticky_sum    = {1'b0, hit_count} + {1'b0, acc_count};
  assign sticky_count  = sticky_sum[CNTW] ? {CNTW{1'b1}} : sticky_sum[CNTW-1:0];

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      acc_pairs   <= '0;
      acc_count   <= '0;
      acc_valid   <= 1'b0;
      acc_x       <= '0;
      acc_y       <= '0;
      collisions  <= '0;
      hit_count   <= '0;
      first_x     <= '0;
      first_y     <= '0;
      first_valid <= 1'b0;
      irq         <= 1'b0;
    end else begin
      // The strobe cycle's own pixel seeds the new frame rather than being dropped.
      if (frame) begin
        acc_pairs <= hit;
        acc_count <= {{(CNTW-1){1'b0}}, hit_any};
        acc_valid <= hit_any;
        acc_x     <= hit_any ? screen_x : '0;
        acc_y     <= hit_any ? screen_y : '0;
      end else begin
        acc_pairs <= acc_pairs | hit;
        if (hit_any) begin
          acc_count <= acc_count_inc;
        end
        if (hit_any && !acc_valid) begin
          acc_valid <= 1'b1;
          acc_x     <= screen_x;
          acc_y     <= screen_y;
        end
      end

      irq <= frame & (|acc_pairs);

      if (frame) begin
        // A clear coinciding with the strobe drops history but keeps the finished frame.
        if (STICKY == 0 || clear) begin
          collisions  <= acc_pairs;
          hit_count   <= acc_count;
          first_x     <= acc_x;
          first_y     <= acc_y;
          first_valid <= acc_valid;
        end else begin
          collisions <= collisions | acc_pairs;
          hit_count  <= sticky_count;
          if (!first_valid && acc_valid) begin
            first_x     <= acc_x;
            first_y     <= acc_y;
            first_valid <= 1'b1;
          end
        end
      end else if (clear) begin
        collisions  <= '0;
        hit_count   <= '0;
        first_x     <= '0;
        first_y     <= '0;
        first_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_collision_unit.sv
// Bench for sprite_collision_unit: three parameterisations share one stimulus stream and
// are compared every cycle against a frame-level model, with literal checks pinning the model.
module tb_sprite_collision_unit;

  logic        clk_pix = 1'b0;
  logic        rst = 1'b1;
  logic        frame = 1'b0;
  logic        de = 1'b0;
  logic [15:0] screen_x = '0;
  logic [15:0] screen_y = '0;
  logic [3:0]  drawing = '0;
  logic [5:0]  pair_mask = 6'b111111;
  logic        clear = 1'b0;

  logic [5:0]  c0, c1, c2;
  logic        any0, any1, any2;
  logic [15:0] fx0, fy0, fx1, fy1, fx2, fy2;
  logic        fv0, fv1, fv2;
  logic [11:0] hc0, hc2;
  logic [3:0]  hc1;
  logic        irq0, irq1, irq2;

  always #5 clk_pix = ~clk_pix;

  sprite_collision_unit u0 (
    .clk_pix(clk_pix), .rst(rst), .frame(frame), .de(de), .screen_x(screen_x), .screen_y(screen_y),
    .drawing(drawing), .pair_mask(pair_mask), .clear(clear), .collisions(c0), .any_collision(any0),
    .first_x(fx0), .first_y(fy0), .first_valid(fv0), .hit_count(hc0), .irq(irq0));

  sprite_collision_unit #(.CNTW(4)) u1 (
    .clk_pix(clk_pix), .rst(rst), .frame(frame), .de(de), .screen_x(screen_x), .screen_y(screen_y),
    .drawing(drawing), .pair_mask(pair_mask), .clear(clear), .collisions(c1), .any_collision(any1),
    .first_x(fx1), .first_y(fy1), .first_valid(fv1), .hit_count(hc1), .irq(irq1));

  sprite_collision_unit #(.STICKY(1)) u2 (
    .clk_pix(clk_pix), .rst(rst), .frame(frame), .de(de), .screen_x(screen_x), .screen_y(screen_y),
    .drawing(drawing), .pair_mask(pair_mask), .clear(clear), .collisions(c2), .any_collision(any2),
    .first_x(fx2), .first_y(fy2), .first_valid(fv2), .hit_count(hc2), .irq(irq2));

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  // Model: frame accumulator with an unbounded count, saturated only when published.
  logic [5:0]  a_pairs = '0;
  int          a_cnt = 0;
  logic        a_valid = 1'b0;
  logic [15:0] a_x = '0, a_y = '0;
  logic [5:0]  e_pairs = '0;
  int          e_cnt = 0, e_cnt1 = 0;
  logic        e_valid = 1'b0, e_irq = 1'b0;
  logic [15:0] e_x = '0, e_y = '0;
  logic [5:0]  s_pairs = '0;
  int          s_cnt = 0;
  logic        s_valid = 1'b0;
  logic [15:0] s_x = '0, s_y = '0;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [5:0] h;
    int k;
    logic hany;
    if (rst) begin
      a_pairs = '0; a_cnt = 0; a_valid = 0; a_x = '0; a_y = '0;
      e_pairs = '0; e_cnt = 0; e_cnt1 = 0; e_valid = 0; e_irq = 0; e_x = '0; e_y = '0;
      s_pairs = '0; s_cnt = 0; s_valid = 0; s_x = '0; s_y = '0;
      return;
    end
    h = '0;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        h[k] = de & drawing[i] & drawing[j] & pair_mask[k];
        k++;
      end
    end
    hany = (h != 0);
    if (frame) begin
      e_irq   = (a_pairs != 0);
      e_pairs = a_pairs;
      e_cnt   = sat(a_cnt, 4095);
      e_cnt1  = sat(a_cnt, 15);
      e_valid = a_valid; e_x = a_x; e_y = a_y;
      if (clear) begin
        s_pairs = e_pairs; s_cnt = e_cnt; s_valid = e_valid; s_x = e_x; s_y = e_y;
      end else begin
        s_pairs = s_pairs | a_pairs;
        s_cnt   = sat(s_cnt + e_cnt, 4095);
        if (!s_valid && a_valid) begin
          s_valid = 1; s_x = a_x; s_y = a_y;
        end
      end
      a_pairs = h; a_cnt = hany ? 1 : 0; a_valid = hany;
      a_x = hany ? screen_x : '0;
      a_y = hany ? screen_y : '0;
    end else begin
      e_irq = 0;
      if (clear) begin
        e_pairs = '0; e_cnt = 0; e_cnt1 = 0; e_valid = 0; e_x = '0; e_y = '0;
        s_pairs = '0; s_cnt = 0; s_valid = 0; s_x = '0; s_y = '0;
      end
      a_pairs = a_pairs | h;
      if (hany) begin
        a_cnt++;
        if (!a_valid) begin
          a_valid = 1; a_x = screen_x; a_y = screen_y;
        end
      end
    end
  endtask

  always @(negedge clk_pix) begin
    if (chk_en) begin
      cmp("u0_coll", c0, e_pairs);
      cmp("u0_any", any0, e_pairs != 0);
      cmp("u0_fx", fx0, e_x);
      cmp("u0_fy", fy0, e_y);
      cmp("u0_fv", fv0, e_valid);
      cmp("u0_cnt", hc0, e_cnt);
      cmp("u0_irq", irq0, e_irq);
      cmp("u1_coll", c1, e_pairs);
      cmp("u1_cnt", hc1, e_cnt1);
      cmp("u1_irq", irq1, e_irq);
      cmp("u2_coll", c2, s_pairs);
      cmp("u2_any", any2, s_pairs != 0);
      cmp("u2_fx", fx2, s_x);
      cmp("u2_fy", fy2, s_y);
      cmp("u2_fv", fv2, s_valid);
      cmp("u2_cnt", hc2, s_cnt);
      cmp("u2_irq", irq2, e_irq);
    end
  end

  task automatic apply(input logic f, input logic d, input logic [15:0] x, input logic [15:0] y,
                       input logic [3:0] drw, input logic c, input logic r);
    @(negedge clk_pix);
    frame = f; de = d; screen_x = x; screen_y = y; drawing = drw; clear = c; rst = r;
    @(posedge clk_pix);
    #1;
    model_update();
  endtask

  task automatic pix(input logic [15:0] x, input logic [15:0] y, input logic [3:0] drw);
    apply(1'b0, 1'b1, x, y, drw, 1'b0, 1'b0);
  endtask

  task automatic strobe();
    apply(1'b1, 1'b0, 16'd0, 16'd0, 4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    apply(0, 0, 0, 0, 0, 0, 1);
    chk_en = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 0);
    cmp("rst_coll", c0, 6'd0);
    cmp("rst_cnt", hc0, 12'd0);
    cmp("rst_fv", fv0, 1'b0);
    cmp("rst_irq", irq0, 1'b0);

    // 4x4 overlap of sprites 0 and 1 at (70,270)
    strobe();
    for (int yy = 270; yy < 274; yy++) begin
      pix(16'd60, 16'(yy), 4'b0001);
      for (int xx = 70; xx < 74; xx++) pix(16'(xx), 16'(yy), 4'b0011);
      pix(16'd80, 16'(yy), 4'b0010);
    end
    strobe();
    cmp("t1_coll", c0, 6'b000001);
    cmp("t1_cnt", hc0, 12'd16);
    cmp("t1_fx", fx0, 16'd70);
    cmp("t1_fy", fy0, 16'd270);
    cmp("t1_fv", fv0, 1'b1);
    cmp("t1_irq", irq0, 1'b1);
    cmp("t1_mdl_cnt", e_cnt, 16);
    apply(0, 0, 0, 0, 0, 0, 0);
    cmp("t1_irq_one", irq0, 1'b0);

    // Three sprites at one pixel, then with pair 1 masked
    pix(16'd100, 16'd50, 4'b0111);
    strobe();
    cmp("t2_coll", c0, 6'b001011);
    cmp("t2_cnt", hc0, 12'd1);
    cmp("t2_mdl_coll", e_pairs, 6'b001011);
    pair_mask = 6'b111101;
    pix(16'd100, 16'd50, 4'b0111);
    strobe();
    cmp("t2m_coll", c0, 6'b001001);
    pair_mask = 6'b111111;

    // Counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) pix(16'(i), 16'd5, 4'b0011);
    strobe();
    cmp("t3_cnt4", hc1, 4'd15);
    cmp("t3_cnt12", hc0, 12'd20);

    // Sticky accumulation across frames, then clear
    apply(0, 0, 0, 0, 0, 1, 0);
    cmp("t4_clr0", c2, 6'd0);
    pix(16'd10, 16'd10, 4'b0011);
    strobe();
    cmp("t4a_coll", c2, 6'b000001);
    cmp("t4a_irq", irq2, 1'b1);
    pix(16'd20, 16'd20, 4'b1100);
    strobe();
    cmp("t4b_coll", c2, 6'b100001);
    cmp("t4b_fx", fx2, 16'd10);
    cmp("t4b_fy", fy2, 16'd10);
    cmp("t4b_cnt", hc2, 12'd2);
    cmp("t4b_irq", irq2, 1'b1);
    cmp("t4b_mdl_coll", s_pairs, 6'b100001);
    apply(0, 0, 0, 0, 0, 1, 0);
    cmp("t4c_coll", c2, 6'd0);
    cmp("t4c_cnt", hc2, 12'd0);
    cmp("t4c_fv", fv2, 1'b0);
    cmp("t4c_u0coll", c0, 6'd0);
    pix(16'd30, 16'd30, 4'b0101);
    apply(1, 0, 0, 0, 0, 1, 0);
    cmp("t4d_coll", c2, 6'b000010);
    cmp("t4d_fx", fx2, 16'd30);
    cmp("t4d_cnt", hc2, 12'd1);

    // de low hits are ignored; hit on the frame cycle goes to the next frame
    apply(0, 0, 16'd40, 16'd40, 4'b0011, 0, 0);
    strobe();
    cmp("t5_coll", c0, 6'd0);
    cmp("t5_irq", irq0, 1'b0);
    apply(1, 1, 16'd50, 16'd60, 4'b0011, 0, 0);
    cmp("t5f_coll", c0, 6'd0);
    cmp("t5f_irq", irq0, 1'b0);
    strobe();
    cmp("t5n_coll", c0, 6'b000001);
    cmp("t5n_fx", fx0, 16'd50);
    cmp("t5n_fy", fy0, 16'd60);
    cmp("t5n_irq", irq0, 1'b1);

    // Reset mid-frame discards accumulated hits
    pix(16'd5, 16'd5, 4'b0011);
    pix(16'd6, 16'd5, 4'b0011);
    apply(0, 0, 0, 0, 0, 0, 1);
    strobe();
    cmp("t6_coll", c0, 6'd0);
    cmp("t6_cnt", hc0, 12'd0);
    cmp("t6_irq", irq0, 1'b0);
    cmp("t6_fv", fv0, 1'b0);
    pix(16'd7, 16'd8, 4'b1001);
    strobe();
    cmp("t6b_coll", c0, 6'b000100);
    cmp("t6b_cnt", hc0, 12'd1);
    apply(0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_collision_unit.md
# sprite_collision_unit

Per-frame collision detector for up to N sprites on the 640x480 pixel stream. Samples each sprite's `drawing` flag every pixel clock, accumulates pairwise overlaps over a frame, and publishes a latched pair-collision vector, first-hit coordinates, a hit-pixel count and an interrupt pulse at each `frame` strobe. Sits between the sprite generators and game logic, replacing the single spaceship/obstacle collision register.

## Interface
- `N_SPRITES`, 4: number of sprite `drawing` inputs (2..8).
- `SCREEN_CORDW`, 16: width of screen coordinates.
- `CNTW`, 12: width of the hit-pixel counter.
- `STICKY`, 0: 0 = results replaced every frame; 1 = results OR-accumulate across frames until `clear`.
- Derived: `NPAIRS = N_SPRITES*(N_SPRITES-1)/2`.

- `clk_pix` in 1: pixel clock, sole clock.
- `rst` in 1: synchronous, active-high reset.
- `frame` in 1: one-cycle start-of-frame strobe from display timing.
- `de` in 1: visible-region flag; only `de`-high pixels count.
- `screen_x`, `screen_y` in SCREEN_CORDW each: current pixel position.
- `drawing` in N_SPRITES: per-sprite drawing flag for the current pixel.
- `pair_mask` in NPAIRS: 1 = pair enabled; disabled pairs never set any result.
- `clear` in 1: one-cycle request to zero published results.
- `collisions` out NPAIRS: latched per-pair collision bits.
- `any_collision` out 1: OR of `collisions`.
- `first_x`, `first_y` out SCREEN_CORDW each: position of first enabled hit.
- `first_valid` out 1: `first_x/first_y` hold a real hit.
- `hit_count` out CNTW: number of pixels with at least one enabled hit, saturating.
- `irq` out 1: one-cycle pulse when a newly latched frame contains a hit.

## Operation
- Pair index k enumerates (i,j), i<j, i-major: for N=4, (0,1)=0, (0,2)=1, (0,3)=2, (1,2)=3, (1,3)=4, (2,3)=5.
- Per cycle: `hit[k] = de & drawing[i] & drawing[j] & pair_mask[k]`; `hit_any = |hit`.
- Accumulator (internal) per frame: `acc_pairs |= hit`; `acc_count += hit_any`, saturating at 2^CNTW-1 (no wrap); on the first `hit_any` of the frame, capture `acc_x/acc_y` from `screen_x/screen_y` and set `acc_valid`. Later hits do not overwrite.
- On `frame`: publish, then reset accumulator. The pixel sampled on the `frame` cycle is discarded if `de` is low; if `de` is high it counts toward the new frame (accumulator loads that cycle's hit instead of zero).
- Publish, STICKY=0: `collisions<=acc_pairs`, `hit_count<=acc_count`, `first_*<=acc_*`, `first_valid<=acc_valid`.
- Publish, STICKY=1: `collisions |= acc_pairs`; `hit_count` saturating-adds `acc_count`; `first_*` update only if `first_valid` is 0 and `acc_valid` is 1.
- `irq` pulses iff `acc_pairs` (this frame only, regardless of STICKY) is nonzero.
- `clear` without `frame`: all published outputs go to 0; accumulator unaffected.
- `clear` with `frame`: publish as STICKY=0, so the history is dropped and the just-finished frame is kept.
- Changing `pair_mask` mid-frame applies from the next sampled pixel. Bits already accumulated are kept.
- `any_collision` is combinational from `collisions`.

## Timing
- Every register, including `irq`, is reset to 0 by `rst`. `first_x`, `first_y`, `hit_count`, `collisions` and `first_valid` are all 0 after reset.
- `rst` mid-frame discards the accumulator. The first `frame` after reset publishes only the pixels seen since `rst` deasserted.
- Input-to-accumulator latency: 1 cycle.
- Published outputs and `irq` change on the `clk_pix` edge that samples `frame` high, and are visible the following cycle.
- `irq` is high for exactly 1 cycle per qualifying frame.
- Outputs hold stable between `frame` strobes except for `clear` and `rst`.
- No input stalls; throughput is one pixel per clock.

## Test plan
- Reset, then one frame with sprites 0 and 1 overlapping in a 4x4 block at (70,270), mask all ones -> `collisions`=6'b000001, `hit_count`=16, `first`=(70,270), `first_valid`=1, one `irq` pulse.
- Sprites 0, 1 and 2 all overlapping at one pixel (100,50) -> `collisions`=6'b001011, `hit_count`=1. Repeat with `pair_mask[1]`=0 -> 6'b001001.
- CNTW=4, 20 hit pixels in a frame -> `hit_count`=15, saturated.
- STICKY=1: frame A hits pair 0 at (10,10), frame B hits pair 5 at (20,20) -> `collisions`=6'b100001, `first`=(10,10), `irq` each frame. Then `clear` alone -> all outputs 0.
- Hits with `de`=0, plus a frame with no hits -> `collisions`=0, no `irq`. `frame` and `de` high with a hit on the same cycle -> that hit is reported in the next frame.
- Assert `rst` mid-frame after hits, then `frame` -> all outputs 0 and no `irq`.
